// File: rtl/x_23k640_model.sv
`default_nettype none
// ============================================================================
// Module   : x_23k640_model
// Purpose  : SPI mode-0 responder emulating a 23K640 serial SRAM (READ, WRITE,
//            RDSR, WRSR with byte, page and sequential modes).
// Revision : 1.0
// ============================================================================
module x_23k640_model #(
    parameter int ADDR_W = 13,
    parameter int PAGE_W = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    input  logic i_cs,
    input  logic i_si,
    output logic o_so,
    output logic o_cmd_err
);

    localparam int          C_DEPTH     = 2 ** ADDR_W;
    localparam logic [7:0]  C_CMD_READ  = 8'h03;
    localparam logic [7:0]  C_CMD_WRITE = 8'h02;
    localparam logic [7:0]  C_CMD_RDSR  = 8'h05;
    localparam logic [7:0]  C_CMD_WRSR  = 8'h01;
    localparam logic [4:0]  C_BITS_BYTE = 5'd8;
    localparam logic [4:0]  C_BITS_ADDR = 5'd16;

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_RDATA  = 3'd3,
        S_RDSR   = 3'd4,
        S_WRSR   = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                sck_q;
    logic [4:0]          cnt_q, cnt_d;
    logic [15:0]         sreg_q, sreg_d;
    logic [7:0]          out_sreg_q, out_sreg_d;
    logic                so_q, so_d;
    logic                cmd_err_q, cmd_err_d;
    logic [7:0]          status_q, status_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_rd_q, is_rd_d;
    logic                load_q, load_d;
    logic [7:0]          rd_data_q, rd_data_d;

    logic [7:0]          mem [C_DEPTH];

    logic                w_rise;
    logic                w_fall;
    logic [15:0]         w_sreg_in;
    logic [4:0]          w_cnt_inc;
    logic                w_seq_mode;
    logic                w_page_mode;
    logic                w_byte_mode;
    logic [ADDR_W-1:0]   w_addr_adv;
    logic                w_mem_we;
    logic [7:0]          w_mem_wdata;

    assign w_rise      = i_sck & ~sck_q;
    assign w_fall      = ~i_sck & sck_q;
    assign w_sreg_in   = {sreg_q[14:0], i_si};
    assign w_cnt_inc   = cnt_q + 5'd1;
    assign w_seq_mode  = (status_q[7:6] == 2'b01);
    assign w_page_mode = (status_q[7:6] == 2'b10);
    // Mode 11 is reserved on the real part and behaves as byte mode here.
    assign w_byte_mode = ~(w_seq_mode | w_page_mode);

    always_comb begin
        w_addr_adv = addr_q;
        if (w_seq_mode) begin
            w_addr_adv = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (w_page_mode) begin
            w_addr_adv[PAGE_W-1:0] = addr_q[PAGE_W-1:0] + {{(PAGE_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        out_sreg_d  = out_sreg_q;
        so_d        = so_q;
        cmd_err_d   = 1'b0;
        status_d    = status_q;
        addr_d      = addr_q;
        is_rd_d     = is_rd_q;
        load_d      = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = w_sreg_in[7:0];

        if (i_cs) begin
            // Deselect wins over any edge in the same cycle, dropping partial bytes.
            state_d = S_CMD;
            cnt_d   = 5'd0;
            sreg_d  = 16'd0;
            so_d    = 1'b0;
        end else begin
            if (load_q) begin
                out_sreg_d = rd_data_q;
            end
            if (w_rise) begin
                sreg_d = w_sreg_in;
                cnt_d  = w_cnt_inc;
                case (state_q)
                    S_CMD: begin
                        if (w_cnt_inc == C_BITS_BYTE) begin
                            cnt_d = 5'd0;
                            case (w_sreg_in[7:0])
                                C_CMD_READ:  begin state_d = S_ADDR; is_rd_d = 1'b1; end
                                C_CMD_WRITE: begin state_d = S_ADDR; is_rd_d = 1'b0; end
                                C_CMD_RDSR:  begin state_d = S_RDSR; out_sreg_d = status_q; end
                                C_CMD_WRSR:  state_d = S_WRSR;
                                default:     begin state_d = S_IGNORE; cmd_err_d = 1'b1; end
                            endcase
                        end
                    end
                    S_ADDR: begin
                        if (w_cnt_inc == C_BITS_ADDR) begin
                            cnt_d  = 5'd0;
                            addr_d = w_sreg_in[ADDR_W-1:0];
                            if (is_rd_q) begin
                                state_d = S_RDATA;
                                load_d  = 1'b1;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_cnt_inc == C_BITS_BYTE) begin
                            cnt_d    = 5'd0;
                            w_mem_we = 1'b1;
                            if (w_byte_mode) state_d = S_IGNORE;
                            else             addr_d  = w_addr_adv;
                        end
                    end
                    S_RDATA: begin
                        if (w_cnt_inc == C_BITS_BYTE) begin
                            cnt_d = 5'd0;
                            if (w_byte_mode) begin
                                state_d = S_IGNORE;
                            end else begin
                                addr_d = w_addr_adv;
                                load_d = 1'b1;
                            end
                        end
                    end
                    S_RDSR: begin
                        if (w_cnt_inc == C_BITS_BYTE) begin
                            cnt_d      = 5'd0;
                            out_sreg_d = status_q;
                        end
                    end
                    S_WRSR: begin
                        if (w_cnt_inc == C_BITS_BYTE) begin
                            cnt_d    = 5'd0;
                            status_d = {w_sreg_in[7:6], 6'b0};
                            state_d  = S_IGNORE;
                        end
                    end
                    default: cnt_d = 5'd0;
                endcase
            end
            if (w_fall) begin
                if ((state_q == S_RDATA) || (state_q == S_RDSR)) begin
                    so_d       = out_sreg_q[7];
                    out_sreg_d = {out_sreg_q[6:0], 1'b0};
                end else begin
                    so_d = 1'b0;
                end
            end
        end
    end

    // Read port follows the next address so the byte is ready before the next SCK fall.
    always_comb begin
        rd_data_d = mem[addr_d];
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            mem[addr_q] <= w_mem_wdata;
        end
        rd_data_q <= rd_data_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_CMD;
            sck_q      <= 1'b0;
            cnt_q      <= 5'd0;
            sreg_q     <= 16'd0;
            out_sreg_q <= 8'd0;
            so_q       <= 1'b0;
            cmd_err_q  <= 1'b0;
            status_q   <= 8'd0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_q      <= i_sck;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            out_sreg_q <= out_sreg_d;
            so_q       <= so_d;
            cmd_err_q  <= cmd_err_d;
            status_q   <= status_d;
            addr_q     <= addr_d;
            is_rd_q    <= is_rd_d;
            load_q     <= load_d;
        end
    end

    assign o_so      = so_q;
    assign o_cmd_err = cmd_err_q;

endmodule
`default_nettype wire
